// File: rtl/bus_rr_arbiter_if.sv
// rtl/bus_rr_arbiter_if.sv - request-side and target-side bus bundle for the round-robin arbiter
interface bus_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    // Command codes: NULL=0, WR=1, RD=2. Response codes: NULL=0, DVA=1, ERR=3.
    logic [NUM_MASTERS-1:0][1:0]            s_MCmd;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_MAddr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_MData;
    logic [NUM_MASTERS-1:0]                 s_MRespAccept;
    logic [NUM_MASTERS-1:0]                 s_SCmdAccept;
    logic [NUM_MASTERS-1:0]                 s_SDataAccept;
    logic [NUM_MASTERS-1:0][1:0]            s_SResp;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_SData;

    logic [1:0]            m_MCmd;
    logic [ADDR_WIDTH-1:0] m_MAddr;
    logic [DATA_WIDTH-1:0] m_MData;
    logic                  m_MRespAccept;
    logic                  m_SCmdAccept;
    logic [1:0]            m_SResp;
    logic [DATA_WIDTH-1:0] m_SData;

    modport slave (
        input  s_MCmd, s_MAddr, s_MData, s_MRespAccept,
        input  m_SCmdAccept, m_SResp, m_SData,
        output s_SCmdAccept, s_SDataAccept, s_SResp, s_SData,
        output m_MCmd, m_MAddr, m_MData, m_MRespAccept
    );

    modport master (
        output s_MCmd, s_MAddr, s_MData, s_MRespAccept,
        output m_SCmdAccept, m_SResp, m_SData,
        input  s_SCmdAccept, s_SDataAccept, s_SResp, s_SData,
        input  m_MCmd, m_MAddr, m_MData, m_MRespAccept
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter, one outstanding transaction, N masters onto one target
// Optional response timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           Clk,
    input  logic                           MReset_n,
    bus_rr_arbiter_if.slave                bus,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_idx,
`ifdef BUS_ARB_TIMEOUT_EN
    output logic                           timeout_o,
`endif
    output logic                           busy
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [1:0] CMD_NULL  = 2'd0;
    localparam logic [1:0] RESP_NULL = 2'd0;

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick, cand;
    logic             req_any;
    logic             resp_done;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
    localparam logic [CNT_W-1:0] T_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out;

    // Counter saturates one past the limit so the timeout pulse fires once.
    assign timed_out = (state_q == RESP) && (cnt_q >= T_LIM);
    assign timeout_o = (state_q == RESP) && (cnt_q == T_LIM);
    assign resp_done = timed_out || (bus.m_SResp != RESP_NULL);
`else
    assign resp_done = (bus.m_SResp != RESP_NULL);
`endif

    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);

    // Walk from last+N down to last+1 so the nearest requester after last wins.
    always_comb begin
        req_any = 1'b0;
        pick    = last_q;
        cand    = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_MASTERS);
            if (bus.s_MCmd[cand] != CMD_NULL) begin
                req_any = 1'b1;
                pick    = cand;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!MReset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (bus.s_MCmd[grant_q] == CMD_NULL) begin
                    state_d = IDLE;
                end else if (bus.m_SCmdAccept) begin
                    last_d  = grant_q;
                    state_d = RESP;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            RESP: begin
`ifdef BUS_ARB_TIMEOUT_EN
                if (cnt_q <= T_LIM && (bus.m_SResp == RESP_NULL || cnt_q == T_LIM))
                    cnt_d = cnt_q + 1'b1;
`endif
                if (resp_done && bus.s_MRespAccept[grant_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m_MCmd        = CMD_NULL;
        bus.m_MAddr       = '0;
        bus.m_MData       = '0;
        bus.m_MRespAccept = 1'b0;
        bus.s_SCmdAccept  = '0;
        bus.s_SResp       = '0;
        bus.s_SData       = '0;
        case (state_q)
            IDLE: begin
`ifdef BUS_ARB_TIMEOUT_EN
                bus.m_MRespAccept = 1'b1;
`endif
            end
            CMD: begin
                bus.m_MCmd                = bus.s_MCmd[grant_q];
                bus.m_MAddr               = bus.s_MAddr[grant_q];
                bus.m_MData               = bus.s_MData[grant_q];
                bus.s_SCmdAccept[grant_q] = bus.m_SCmdAccept;
            end
            RESP: begin
                bus.m_MRespAccept    = bus.s_MRespAccept[grant_q];
                bus.s_SResp[grant_q] = bus.m_SResp;
                bus.s_SData[grant_q] = bus.m_SData;
`ifdef BUS_ARB_TIMEOUT_EN
                if (timed_out) begin
                    bus.s_SResp[grant_q] = 2'd3;
                    bus.s_SData[grant_q] = '0;
                end
`endif
            end
            default: ;
        endcase
    end

    assign bus.s_SDataAccept = bus.s_SCmdAccept;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - directed self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] C_NULL = 2'd0, C_WR = 2'd1, C_RD = 2'd2;
    localparam logic [1:0] R_NULL = 2'd0, R_DVA = 2'd1, R_ERR = 2'd3;

    logic       Clk;
    logic       MReset_n;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;
    int         n_checks;
    int         n_fail;

    bus_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    bus_rr_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .Clk       (Clk),
        .MReset_n  (MReset_n),
        .bus       (bif),
        .grant_idx (grant_idx),
`ifdef BUS_ARB_TIMEOUT_EN
        .timeout_o (timeout),
`endif
        .busy      (busy)
    );

`ifndef BUS_ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin
            bif.s_MCmd[i]  = C_NULL;
            bif.s_MAddr[i] = '0;
            bif.s_MData[i] = '0;
        end
        bif.s_MRespAccept = '0;
        bif.m_SCmdAccept  = 1'b0;
        bif.m_SResp       = R_NULL;
        bif.m_SData       = '0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        MReset_n = 1'b0;
        idle_inputs();
        @(negedge Clk);
        MReset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        MReset_n = 1'b0;
        idle_inputs();
        bif.s_MCmd[1] = C_RD;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0h expected 0", grant_idx); end
        n_checks++; if (bif.m_MCmd !== C_NULL) begin n_fail++; $display("FAIL reset_mcmd: got %0h expected 0", bif.m_MCmd); end
        n_checks++; if (bif.s_SCmdAccept !== 4'b0000) begin n_fail++; $display("FAIL reset_accept: got %0h expected 0", bif.s_SCmdAccept); end
        n_checks++; if (bif.s_SResp !== 8'h00) begin n_fail++; $display("FAIL reset_sresp: got %0h expected 0", bif.s_SResp); end
        MReset_n = 1'b1;
        bif.s_MCmd[1] = C_NULL;
    endtask

    task automatic test_single_read();
        do_reset();
        bif.s_MCmd[1]   = C_RD;
        bif.s_MAddr[1]  = 32'h4;
        bif.m_SCmdAccept = 1'b1;
        #1;
        n_checks++; if (bif.m_MCmd !== C_NULL) begin n_fail++; $display("FAIL rd_latency: got %0h expected 0", bif.m_MCmd); end
        @(negedge Clk); #1;
        n_checks++; if (grant_idx !== 2'd1) begin n_fail++; $display("FAIL rd_grant: got %0h expected 1", grant_idx); end
        n_checks++; if (bif.m_MCmd !== C_RD || bif.m_MAddr !== 32'h4) begin n_fail++; $display("FAIL rd_fwd: got cmd %0h addr %0h expected cmd 2 addr 4", bif.m_MCmd, bif.m_MAddr); end
        n_checks++; if (bif.s_SCmdAccept !== 4'b0010 || bif.s_SDataAccept !== 4'b0010) begin n_fail++; $display("FAIL rd_accept: got %0h/%0h expected 2/2", bif.s_SCmdAccept, bif.s_SDataAccept); end
        @(negedge Clk);
        bif.s_MCmd[1] = C_NULL;
        bif.m_SCmdAccept = 1'b0;
        #1;
        n_checks++; if (bif.m_MCmd !== C_NULL || busy !== 1'b1) begin n_fail++; $display("FAIL rd_resp_wait: got cmd %0h busy %0h expected 0/1", bif.m_MCmd, busy); end
        @(negedge Clk);
        @(negedge Clk);
        bif.m_SResp = R_DVA;
        bif.m_SData = 32'hCAFE;
        bif.s_MRespAccept = 4'b0010;
        #1;
        n_checks++; if (bif.s_SResp[1] !== R_DVA || bif.s_SData[1] !== 32'hCAFE) begin n_fail++; $display("FAIL rd_resp1: got %0h/%0h expected 1/cafe", bif.s_SResp[1], bif.s_SData[1]); end
        n_checks++; if (bif.s_SResp[0] !== R_NULL || bif.s_SData[0] !== 32'h0) begin n_fail++; $display("FAIL rd_resp0: got %0h/%0h expected 0/0", bif.s_SResp[0], bif.s_SData[0]); end
        n_checks++; if (bif.m_MRespAccept !== 1'b1) begin n_fail++; $display("FAIL rd_mrespacc: got %0h expected 1", bif.m_MRespAccept); end
        @(negedge Clk);
        idle_inputs();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_done: got busy %0h expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order [5];
        logic       found;
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < N; i++) begin
            bif.s_MCmd[i]  = C_RD;
            bif.s_MAddr[i] = 32'h10 * i;
        end
        bif.m_SCmdAccept  = 1'b1;
        bif.m_SResp       = R_DVA;
        bif.s_MRespAccept = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge Clk); #1;
                if (bif.m_MCmd !== C_NULL) found = 1'b1;
            end
            n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rr_timeout[%0d]: got no command expected one", k); end
            n_checks++; if (grant_idx !== exp_order[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grant_idx, exp_order[k]); end
            n_checks++; if (bif.m_MAddr !== 32'h10 * exp_order[k]) begin n_fail++; $display("FAIL rr_addr[%0d]: got %0h expected %0h", k, bif.m_MAddr, 32'h10 * exp_order[k]); end
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        bif.s_MCmd[1]     = C_RD;
        bif.m_SCmdAccept  = 1'b1;
        bif.m_SResp       = R_DVA;
        bif.s_MRespAccept = 4'b1111;
        @(negedge Clk);
        @(negedge Clk);
        bif.s_MCmd[1]  = C_NULL;
        bif.s_MCmd[2]  = C_WR;
        bif.s_MData[2] = 32'hA5;
        bif.s_MCmd[0]  = C_RD;
        @(negedge Clk);
        @(negedge Clk); #1;
        n_checks++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL prio_grant: got %0d expected 2", grant_idx); end
        n_checks++; if (bif.m_MCmd !== C_WR || bif.m_MData !== 32'hA5) begin n_fail++; $display("FAIL prio_wr: got %0h/%0h expected 1/a5", bif.m_MCmd, bif.m_MData); end
        n_checks++; if (bif.s_SCmdAccept !== 4'b0100) begin n_fail++; $display("FAIL prio_accept: got %0h expected 4", bif.s_SCmdAccept); end
        @(negedge Clk);
        bif.s_MCmd[2] = C_NULL;
        @(negedge Clk);
        @(negedge Clk); #1;
        n_checks++; if (grant_idx !== 2'd0 || bif.m_MCmd !== C_RD) begin n_fail++; $display("FAIL prio_second: got %0d/%0h expected 0/2", grant_idx, bif.m_MCmd); end
        idle_inputs();
    endtask

    task automatic test_accept_stall();
        do_reset();
        bif.s_MCmd[0]  = C_WR;
        bif.s_MAddr[0] = 32'h30;
        bif.s_MData[0] = 32'h33;
        bif.s_MCmd[2]  = C_RD;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk); #1;
            n_checks++; if (busy !== 1'b1 || grant_idx !== 2'd0) begin n_fail++; $display("FAIL stall_grant[%0d]: got busy %0h grant %0d expected 1/0", c, busy, grant_idx); end
            n_checks++; if (bif.m_MCmd !== C_WR || bif.m_MAddr !== 32'h30 || bif.s_SCmdAccept !== 4'b0000) begin n_fail++; $display("FAIL stall_cmd[%0d]: got %0h/%0h/%0h expected 1/30/0", c, bif.m_MCmd, bif.m_MAddr, bif.s_SCmdAccept); end
        end
        @(negedge Clk);
        bif.m_SCmdAccept = 1'b1;
        #1;
        n_checks++; if (bif.s_SCmdAccept !== 4'b0001) begin n_fail++; $display("FAIL stall_release: got %0h expected 1", bif.s_SCmdAccept); end
        @(negedge Clk);
        bif.s_MCmd[0] = C_NULL;
        bif.m_SResp = R_DVA;
        bif.s_MRespAccept = 4'b0001;
        @(negedge Clk);
        @(negedge Clk); #1;
        n_checks++; if (grant_idx !== 2'd2 || bif.m_MCmd !== C_RD) begin n_fail++; $display("FAIL stall_next: got %0d/%0h expected 2/2", grant_idx, bif.m_MCmd); end
        idle_inputs();
    endtask

    task automatic test_drop_in_cmd();
        do_reset();
        bif.s_MCmd[1] = C_RD;
        @(negedge Clk);
        @(negedge Clk);
        bif.s_MCmd[1] = C_NULL;
        #1;
        n_checks++; if (bif.m_MCmd !== C_NULL || bif.s_SCmdAccept !== 4'b0000) begin n_fail++; $display("FAIL drop_fwd: got %0h/%0h expected 0/0", bif.m_MCmd, bif.s_SCmdAccept); end
        @(negedge Clk);
        bif.s_MCmd[0] = C_RD;
        bif.s_MCmd[2] = C_RD;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got busy %0h expected 0", busy); end
        @(negedge Clk); #1;
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL drop_last: got %0d expected 0", grant_idx); end
        idle_inputs();
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        bif.s_MCmd[1]    = C_RD;
        bif.m_SCmdAccept = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        bif.s_MCmd[1]    = C_NULL;
        bif.m_SCmdAccept = 1'b0;
        MReset_n         = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b1 || grant_idx !== 2'd1) begin n_fail++; $display("FAIL rstresp_pre: got %0h/%0d expected 1/1", busy, grant_idx); end
        @(negedge Clk);
        MReset_n = 1'b1;
        bif.s_MCmd[2] = C_RD;
        #1;
        n_checks++; if (busy !== 1'b0 || grant_idx !== 2'd0) begin n_fail++; $display("FAIL rstresp_state: got %0h/%0d expected 0/0", busy, grant_idx); end
        n_checks++; if (bif.m_MCmd !== C_NULL || bif.s_SResp !== 8'h00 || bif.s_SCmdAccept !== 4'b0000) begin n_fail++; $display("FAIL rstresp_outs: got %0h/%0h/%0h expected 0/0/0", bif.m_MCmd, bif.s_SResp, bif.s_SCmdAccept); end
`ifdef BUS_ARB_TIMEOUT_EN
        n_checks++; if (bif.m_MRespAccept !== 1'b1) begin n_fail++; $display("FAIL rstresp_drain: got %0h expected 1", bif.m_MRespAccept); end
`else
        n_checks++; if (bif.m_MRespAccept !== 1'b0) begin n_fail++; $display("FAIL rstresp_drain: got %0h expected 0", bif.m_MRespAccept); end
`endif
        @(negedge Clk); #1;
        n_checks++; if (grant_idx !== 2'd2 || bif.m_MCmd !== C_RD) begin n_fail++; $display("FAIL rstresp_next: got %0d/%0h expected 2/2", grant_idx, bif.m_MCmd); end
        idle_inputs();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int         pulses;
        logic [1:0] exp_r;
        do_reset();
        bif.s_MCmd[3]    = C_RD;
        bif.s_MAddr[3]   = 32'h3C;
        bif.m_SCmdAccept = 1'b1;
        @(negedge Clk); #1;
        n_checks++; if (grant_idx !== 2'd3) begin n_fail++; $display("FAIL to_grant: got %0d expected 3", grant_idx); end
        @(negedge Clk);
        bif.s_MCmd[3]    = C_NULL;
        bif.m_SCmdAccept = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge Clk);
            if (k == 10) bif.s_MRespAccept[3] = 1'b1;
            #1;
            if (timeout === 1'b1) pulses++;
            exp_r = (k == 9 || k == 10) ? R_ERR : R_NULL;
            n_checks++; if (bif.s_SResp[3] !== exp_r) begin n_fail++; $display("FAIL to_resp[%0d]: got %0h expected %0h", k, bif.s_SResp[3], exp_r); end
            if (k == 9) begin
                n_checks++; if (timeout !== 1'b1 || bif.s_SData[3] !== 32'h0) begin n_fail++; $display("FAIL to_pulse: got %0h/%0h expected 1/0", timeout, bif.s_SData[3]); end
            end
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL to_count: got %0d expected 1", pulses); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %0h expected 0", busy); end
        idle_inputs();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        MReset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_priority();
        test_accept_stall();
        test_drop_in_cmd();
        test_reset_in_resp();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
